sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
- Input conditioner for asynchronous or bouncy single-bit inputs such as buttons and external strobes.
- Synchronises the input into clk, then filters it so the output level only changes after the input has been stable for a programmable number of cycles.
- Sits directly upstream of detect_edge. Its clean level output feeds detect_edge's `in`, so edge pulses are glitch-free.
- Also counts rejected glitches for debug.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (>=2).
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before the output changes (>=2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), stability counter width.
- GLITCH_W, 8, glitch counter width.
- RESET_VAL, 1'b0, reset level of the synchroniser chain and the output.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset, sampled on posedge clk.
- in  input  1  raw asynchronous input.
- en  input  1  filter enable; 0 freezes the FSM and counters.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- out  output  1  debounced level (registered).
- busy  output  1  high while a candidate transition is being qualified.
- glitch_cnt  output  GLITCH_W  saturating count of aborted transitions.

Behaviour:
- Reset: rstn is synchronous and active-low; it takes effect only on a posedge clk where rstn=0. It overrides everything, including mid-qualification.
  - Sync chain = RESET_VAL.
  - state = STABLE_HI if RESET_VAL=1, else STABLE_LO.
  - out = RESET_VAL, busy = 0, cnt = 0, glitch_cnt = 0.
- Synchroniser:
  - SYNC_STAGES-deep shift chain, always running, ignores en.
  - s = last stage.
- FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO. It advances only when en=1; when en=0, state, cnt and out hold.
  - STABLE_LO: s=1 -> CHECK_HI, cnt=1; else stay.
  - CHECK_HI, s=1, cnt==DEBOUNCE_CYCLES-1: -> STABLE_HI, out<=1, cnt=0.
  - CHECK_HI, s=1, otherwise: cnt++.
  - CHECK_HI, s=0: -> STABLE_LO, cnt=0, glitch event.
  - STABLE_HI and CHECK_LO: mirror of STABLE_LO and CHECK_HI with polarities swapped.
- busy = 1 exactly in the CHECK_* states. It is registered, i.e. derived from state.
- Latency: if in is stable from sampling edge k with en=1 throughout, out changes on edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Defaults: k+17.
  - SYNC_STAGES=2, DEBOUNCE_CYCLES=4: k+5.
- A bounce that breaks the run restarts qualification from the next opposite sample; there is no partial credit.
- glitch_cnt:
  - +1 per glitch event, saturating at 2^GLITCH_W-1.
  - glitch_clr=1 forces 0 that cycle and wins over a simultaneous glitch event (result 0).
  - glitch_clr has no effect on the FSM.
- No combinational path from in to any output.

Decomposition:
- Shared package (io_cond_pkg):
  - state enum for STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
  - default constants for SYNC_STAGES and DEBOUNCE_CYCLES.
- One natural sub-module: sync_chain (parameterised N-flop synchroniser with sync reset value). It is reusable wherever async inputs enter.
- Debounce FSM, counters and glitch logic stay in sync_debounce.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0 unless noted):
- Clean step: rstn released, en=1, in 0->1 sampled at edge k -> busy rises after edge k+2, out=1 after edge k+5, busy=0 after edge k+5, glitch_cnt=0.
- Bounce: in 1 for 2 cycles, 0 for 1 cycle, then 1 stable -> out stays 0 through the bounce; glitch_cnt=1; out=1 four FSM samples after s returns to 1.
- Freeze: assert en=0 mid-CHECK_HI with cnt=2 for 10 cycles, in held 1 -> out, busy and cnt held; after en=1, out=1 after 2 more cycles.
- Saturation/clear: GLITCH_W=2, inject 5 glitches -> glitch_cnt=3. glitch_clr coincident with a glitch event -> glitch_cnt=0.
- Reset mid-operation: rstn=0 for one edge while in CHECK_LO with out=1 -> after that edge out=0, busy=0, glitch_cnt=0. With RESET_VAL=1 -> out=1.
- Back-to-back with detect_edge: feed out into detect_edge with in toggling every 20 cycles -> exactly one pedge/nedge pulse per toggle, none during injected bounces.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared types and defaults for the input-conditioning blocks.
// The debounce state encoding is kept here so other conditioners can reuse it.
package io_cond_pkg;

    typedef enum logic [1:0] {
        StableLo,
        CheckHi,
        StableHi,
        CheckLo
    } db_state_e;

    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 16;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for asynchronous single-bit inputs, with a synchronous reset value.
module sync_chain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronise a bouncy input, then only change the output after DEBOUNCE_CYCLES stable samples.
// Aborted qualifications are counted in a saturating glitch counter.
module sync_debounce
    import io_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int unsigned GLITCH_W        = 8,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in,
    input  logic                en,
    input  logic                glitch_clr,
    output logic                out,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                s;
    db_state_e           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                out_q;
    logic [GLITCH_W-1:0] glitch_q;
    logic                glitch_ev;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk_i  (clk),
        .rstn_i (rstn),
        .d_i    (in),
        .q_o    (s)
    );

    // A glitch is a candidate transition whose run of opposite samples is broken.
    always_comb begin
        glitch_ev = 1'b0;
        if (en) begin
            glitch_ev = ((state_q == CheckHi) && !s) || ((state_q == CheckLo) && s);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= RESET_VAL ? StableHi : StableLo;
            cnt_q    <= '0;
            out_q    <= RESET_VAL;
            glitch_q <= '0;
        end else begin
            if (en) begin
                unique case (state_q)
                    StableLo: begin
                        if (s) begin
                            state_q <= CheckHi;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    CheckHi: begin
                        if (!s) begin
                            state_q <= StableLo;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StableHi;
                            out_q   <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StableHi: begin
                        if (!s) begin
                            state_q <= CheckLo;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    CheckLo: begin
                        if (s) begin
                            state_q <= StableHi;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StableLo;
                            out_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StableLo;
                        cnt_q   <= '0;
                    end
                endcase
            end

            // Clear wins over a coincident glitch event.
            if (glitch_clr) begin
                glitch_q <= '0;
            end else if (glitch_ev && (glitch_q != '1)) begin
                glitch_q <= glitch_q + GLITCH_W'(1);
            end
        end
    end

    assign out        = out_q;
    assign busy       = (state_q == CheckHi) || (state_q == CheckLo);
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Two differently parameterised debouncers share one stimulus stream; a run-length
// reference model predicts each cycle's outputs into queues that a monitor drains.
module tb_sync_debounce;

    localparam int unsigned S0 = 2;
    localparam int unsigned D0 = 4;
    localparam int unsigned G0 = 3;
    localparam logic        R0 = 1'b0;
    localparam int unsigned S1 = 3;
    localparam int unsigned D1 = 5;
    localparam int unsigned G1 = 2;
    localparam logic        R1 = 1'b1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_raw = 1'b0;
    logic en = 1'b0;
    logic glitch_clr = 1'b0;

    logic          out0, busy0;
    logic [G0-1:0] gc0;
    logic          out1, busy1;
    logic [G1-1:0] gc1;

    always #5 clk = ~clk;

    sync_debounce #(
        .SYNC_STAGES     (S0),
        .DEBOUNCE_CYCLES (D0),
        .GLITCH_W        (G0),
        .RESET_VAL       (R0)
    ) u_dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in_raw),
        .en         (en),
        .glitch_clr (glitch_clr),
        .out        (out0),
        .busy       (busy0),
        .glitch_cnt (gc0)
    );

    sync_debounce #(
        .SYNC_STAGES     (S1),
        .DEBOUNCE_CYCLES (D1),
        .GLITCH_W        (G1),
        .RESET_VAL       (R1)
    ) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .in         (in_raw),
        .en         (en),
        .glitch_clr (glitch_clr),
        .out        (out1),
        .busy       (busy1),
        .glitch_cnt (gc1)
    );

    typedef struct packed {
        logic       o;
        logic       b;
        logic [7:0] g;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model state: input history (bit 0 newest), output level, run of opposite samples.
    logic [7:0] hist[2];
    logic       mo[2];
    int         run[2];
    int         mg[2];

    function automatic int p_sync(int i);
        return (i == 0) ? int'(S0) : int'(S1);
    endfunction

    function automatic int p_deb(int i);
        return (i == 0) ? int'(D0) : int'(D1);
    endfunction

    function automatic int p_gmax(int i);
        return (i == 0) ? ((1 << G0) - 1) : ((1 << G1) - 1);
    endfunction

    function automatic logic p_rv(int i);
        return (i == 0) ? R0 : R1;
    endfunction

    task automatic model_step(input int i, output exp_t e);
        logic s;
        logic glitch;
        glitch = 1'b0;
        if (!rstn) begin
            hist[i] = p_rv(i) ? 8'hFF : 8'h00;
            mo[i]   = p_rv(i);
            run[i]  = 0;
            mg[i]   = 0;
        end else begin
            s = hist[i][p_sync(i)-1];
            if (en) begin
                if (s != mo[i]) begin
                    run[i]++;
                    if (run[i] == p_deb(i)) begin
                        mo[i]  = s;
                        run[i] = 0;
                    end
                end else if (run[i] > 0) begin
                    run[i] = 0;
                    glitch = 1'b1;
                end
            end
            if (glitch_clr) mg[i] = 0;
            else if (glitch && mg[i] < p_gmax(i)) mg[i]++;
            hist[i] = {hist[i][6:0], in_raw};
        end
        e.o = mo[i];
        e.b = (run[i] > 0);
        e.g = 8'(mg[i]);
    endtask

    task automatic drive(input logic r, input logic x, input logic e_in, input logic c);
        exp_t e;
        @(negedge clk);
        rstn       = r;
        in_raw     = x;
        en         = e_in;
        glitch_clr = c;
        model_step(0, e);
        q0.push_back(e);
        model_step(1, e);
        q1.push_back(e);
    endtask

    task automatic check(input string name, input logic o, input logic b, input logic [7:0] g,
                         input exp_t e);
        vectors++;
        if (o !== e.o || b !== e.b || g !== e.g) begin
            miscompares++;
            $display("FAIL %s out/busy/glitch_cnt got %b/%b/%0d want %b/%b/%0d at %0t",
                     name, o, b, g, e.o, e.b, e.g, $time);
        end
    endtask

    // Monitor: outputs are sampled 1 time unit after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dut0", out0, busy0, 8'(gc0), e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1", out1, busy1, 8'(gc1), e);
            end
        end
    end

    initial begin
        int   seg;
        logic lvl;
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);
        // Clean rising step.
        repeat (12) drive(1'b1, 1'b1, 1'b1, 1'b0);
        // Clean falling step, then a bounce before settling high.
        repeat (12) drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) drive(1'b1, 1'b1, 1'b1, 1'b0);
        // Freeze mid-qualification of a rising edge.
        repeat (12) drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) drive(1'b1, 1'b1, 1'b1, 1'b0);
        // Repeated short low pulses drive the glitch counters into saturation.
        for (int k = 0; k < 9; k++) begin
            repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b0);
            repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0);
        end
        // Clear held across an abort so it coincides with the glitch event.
        repeat (2) drive(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b1, 1'b1, 1'b0);
        // Reset while qualifying a falling edge with out high.
        repeat (4) drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b1, 1'b0);
        // Randomised segments of varying length with sparse disables, clears and resets.
        seg = 0;
        lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (seg == 0) begin
                lvl = 1'($urandom_range(0, 1));
                seg = int'($urandom_range(1, 12));
            end
            seg--;
            drive(1'($urandom_range(0, 199) != 0), lvl, 1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 29) == 0));
        end
        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending got %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
